// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: turns asynchronous 6502-style bus cycles into single-clock register-file strobes
module bus_cycle_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 31,
    parameter int ADDR_W      = 3
) (
    input  logic              clk25,
    input  logic              bus_res_n,
    input  logic              bus_phy2,
    input  logic              bus_cs_n,
    input  logic              bus_rw_n,
    input  logic [ADDR_W-1:0] bus_a,
    input  logic [7:0]        bus_d_in,
    output logic [7:0]        bus_d_out,
    output logic              bus_d_oe,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_done,
    output logic              wr_strobe,
    output logic [7:0]        wr_data,
    output logic              timeout
);
    localparam int SW = ADDR_W + 11;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b1, {(ADDR_W + 9){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD_FETCH, RD_DRIVE, WR_WAIT} state_t;

    state_t state, state_n;
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] warm;
    logic phy2_s, cs_n_s, rw_n_s, phy2_q, armed, rise, fall, to_hit;
    logic fetched, fetched_n;
    logic [ADDR_W-1:0] a_s, rd_addr_n;
    logic [7:0] d_s, bus_d_out_n, wr_data_n;
    logic [CW-1:0] cnt, cnt_n;
    logic rd_req_n, rd_done_n, wr_strobe_n, timeout_n;

    assign {phy2_s, cs_n_s, rw_n_s, a_s, d_s} = sync_q[SYNC_STAGES-1];
    assign rise = phy2_s & ~phy2_q & armed;
    assign fall = ~phy2_s & phy2_q;
    assign to_hit = (state != IDLE) & phy2_s & (cnt == CW'(TIMEOUT - 1));
    assign bus_d_oe = (state == RD_DRIVE) & bus_phy2 & ~bus_cs_n & bus_rw_n;

    // Delay every bus pin through the same synchroniser depth; warm marks when the chain output is trustworthy
    always_ff @(posedge clk25 or negedge bus_res_n) begin
        if (!bus_res_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            warm <= '0;
        end else begin
            sync_q[0] <= {bus_phy2, bus_cs_n, bus_rw_n, bus_a, bus_d_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            warm <= SYNC_STAGES'({warm, 1'b1});
        end
    end

    // Edge history; a cycle already in progress when reset lifts is ignored until PHY2 is seen low
    always_ff @(posedge clk25 or negedge bus_res_n) begin
        if (!bus_res_n) begin
            phy2_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            phy2_q <= phy2_s;
            armed  <= armed | (warm[SYNC_STAGES-1] & ~phy2_s);
        end
    end

    // Sequencer state, held access data and registered one-clock strobes
    always_ff @(posedge clk25 or negedge bus_res_n) begin
        if (!bus_res_n) begin
            state     <= IDLE;
            fetched   <= 1'b0;
            cnt       <= '0;
            rd_addr   <= '0;
            bus_d_out <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_done   <= 1'b0;
            wr_strobe <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            fetched   <= fetched_n;
            cnt       <= cnt_n;
            rd_addr   <= rd_addr_n;
            bus_d_out <= bus_d_out_n;
            wr_data   <= wr_data_n;
            rd_req    <= rd_req_n;
            rd_done   <= rd_done_n;
            wr_strobe <= wr_strobe_n;
            timeout   <= timeout_n;
        end
    end

    // Next state: a rise always starts a fresh access, then timeout abort, then normal per-state progress
    always_comb begin
        state_n     = state;
        fetched_n   = 1'b0;
        cnt_n       = cnt;
        rd_addr_n   = rd_addr;
        bus_d_out_n = bus_d_out;
        wr_data_n   = wr_data;
        rd_req_n    = 1'b0;
        rd_done_n   = 1'b0;
        wr_strobe_n = 1'b0;
        timeout_n   = 1'b0;
        if (rise) begin
            cnt_n     = '0;
            state_n   = cs_n_s ? IDLE : (rw_n_s ? RD_FETCH : WR_WAIT);
            rd_addr_n = cs_n_s ? rd_addr : a_s;
            rd_req_n  = ~cs_n_s & rw_n_s;
        end else if (to_hit) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
            cnt_n     = CW'(TIMEOUT);
        end else begin
            cnt_n       = (state != IDLE && phy2_s && cnt != CW'(TIMEOUT)) ? cnt + CW'(1) : cnt;
            fetched_n   = (state == RD_FETCH) & ~fetched;
            bus_d_out_n = (state == RD_FETCH && fetched) ? rd_data : bus_d_out;
            wr_data_n   = (state == WR_WAIT && phy2_s) ? d_s : wr_data;
            rd_done_n   = (state == RD_DRIVE) & fall;
            wr_strobe_n = (state == WR_WAIT) & fall;
            state_n     = (state == RD_FETCH && fetched) ? RD_DRIVE :
                          (rd_done_n || wr_strobe_n) ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb_bus_cycle_sequencer: directed bus cycles checked against an access-level model and literal expectations
module tb_bus_cycle_sequencer;
    localparam int TIMEOUT = 31;

    logic clk, bus_res_n, bus_phy2, bus_cs_n, bus_rw_n;
    logic [2:0] bus_a, rd_addr;
    logic [7:0] bus_d_in, bus_d_out, rd_data, wr_data;
    logic bus_d_oe, rd_req, rd_done, wr_strobe, timeout;

    bus_cycle_sequencer dut (
        .clk25(clk), .bus_res_n(bus_res_n), .bus_phy2(bus_phy2), .bus_cs_n(bus_cs_n),
        .bus_rw_n(bus_rw_n), .bus_a(bus_a), .bus_d_in(bus_d_in), .bus_d_out(bus_d_out),
        .bus_d_oe(bus_d_oe), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_done(rd_done), .wr_strobe(wr_strobe), .wr_data(wr_data), .timeout(timeout)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;
    int n_rq = 0, n_dn = 0, n_wr = 0, n_to = 0;
    int rq_cyc, dn_cyc, wr_cyc, to_cyc, rise_cyc, fall_cyc;
    int s_rq, s_dn, s_wr, s_to;
    logic [2:0] lw_addr;
    logic [7:0] lw_data, dout_pre;
    logic oe_pre, oe_post;
    logic [7:0] regs [8];

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!bus_res_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h57 + 8'(i);
            rd_data <= 8'h00;
        end else begin
            if (rd_req) rd_data <= regs[rd_addr];
            if (wr_strobe) regs[rd_addr] <= wr_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Access-level model: pins seen two clocks late, each access tracked by kind, age and high-time
    logic h_ph [3], h_cs [3], h_rw [3];
    logic [2:0] h_a [3];
    logic [7:0] h_d [3];
    logic [7:0] m_mem [8];
    logic m_armed, m_req, m_done, m_wr, m_to, m_rise, m_fall;
    int m_kind, m_age, m_hi, m_edges;
    logic [2:0] m_addr;
    logic [7:0] m_wdata, m_dout;

    initial forever begin
        @(posedge clk or negedge bus_res_n);
        if (!bus_res_n) begin
            for (int i = 0; i < 3; i++) begin
                h_ph[i] = 1'b0; h_cs[i] = 1'b1; h_rw[i] = 1'b0; h_a[i] = 3'd0; h_d[i] = 8'd0;
            end
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h57 + 8'(i);
            m_armed = 1'b0; m_req = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_to = 1'b0;
            m_kind = 0; m_age = 0; m_hi = 0; m_edges = 0;
            m_addr = 3'd0; m_wdata = 8'd0; m_dout = 8'd0;
        end else begin
            m_req = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_to = 1'b0;
            m_rise = h_ph[1] & ~h_ph[2] & m_armed;
            m_fall = ~h_ph[1] & h_ph[2];
            if (m_edges >= 2 && !h_ph[1]) m_armed = 1'b1;
            if (m_rise) begin
                m_hi = 0;
                m_age = 0;
                m_kind = h_cs[1] ? 0 : (h_rw[1] ? 1 : 2);
                if (!h_cs[1]) m_addr = h_a[1];
                m_req = ~h_cs[1] & h_rw[1];
            end else if (m_kind != 0) begin
                m_age++;
                if (h_ph[1]) m_hi++;
                if (h_ph[1] && m_hi == TIMEOUT) begin
                    m_to = 1'b1;
                    m_kind = 0;
                end else if (m_kind == 2) begin
                    if (h_ph[1]) m_wdata = h_d[1];
                    if (m_fall) begin
                        m_wr = 1'b1;
                        m_mem[m_addr] = m_wdata;
                        m_kind = 0;
                    end
                end else begin
                    if (m_age == 2) m_dout = m_mem[m_addr];
                    if (m_age >= 3 && m_fall) begin
                        m_done = 1'b1;
                        m_kind = 0;
                    end
                end
            end
            m_edges++;
            for (int i = 2; i > 0; i--) begin
                h_ph[i] = h_ph[i-1]; h_cs[i] = h_cs[i-1]; h_rw[i] = h_rw[i-1];
                h_a[i] = h_a[i-1]; h_d[i] = h_d[i-1];
            end
            h_ph[0] = bus_phy2; h_cs[0] = bus_cs_n; h_rw[0] = bus_rw_n; h_a[0] = bus_a; h_d[0] = bus_d_in;
        end
    end

    // Per-cycle comparison against the model, plus strobe bookkeeping for the literal checks
    initial forever begin
        @(negedge clk);
        check("rd_req", rd_req, m_req);
        check("rd_done", rd_done, m_done);
        check("wr_strobe", wr_strobe, m_wr);
        check("timeout", timeout, m_to);
        check("rd_addr", rd_addr, m_addr);
        check("wr_data", wr_data, m_wdata);
        check("bus_d_out", bus_d_out, m_dout);
        check("bus_d_oe", bus_d_oe, m_kind == 1 && m_age >= 2 && bus_phy2 && !bus_cs_n && bus_rw_n);
        if (rd_req) begin n_rq++; rq_cyc = cyc; end
        if (rd_done) begin n_dn++; dn_cyc = cyc; end
        if (timeout) begin n_to++; to_cyc = cyc; end
        if (wr_strobe) begin n_wr++; wr_cyc = cyc; lw_addr = rd_addr; lw_data = wr_data; end
    end

    task automatic snap();
        s_rq = n_rq; s_dn = n_dn; s_wr = n_wr; s_to = n_to;
    endtask

    task automatic bus_cycle(input logic rw, input logic [2:0] a, input logic [7:0] d, input logic cs, input int hi_ns);
        @(posedge clk);
        #7;
        bus_a = a; bus_rw_n = rw; bus_cs_n = cs;
        #30 bus_phy2 = 1'b1; rise_cyc = cyc;
        #100 if (!rw) bus_d_in = d;
        #(hi_ns - 145) oe_pre = bus_d_oe; dout_pre = bus_d_out;
        #45 bus_phy2 = 1'b0; fall_cyc = cyc;
        #1 oe_post = bus_d_oe;
        #9 bus_cs_n = 1'b1;
        #210;
    endtask

    initial begin
        bus_res_n = 1'b0; bus_phy2 = 1'b0; bus_cs_n = 1'b1; bus_rw_n = 1'b1; bus_a = 3'd0; bus_d_in = 8'd0;
        #110 bus_res_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst rd_addr", rd_addr, 0);
        check("rst bus_d_out", bus_d_out, 0);
        check("rst wr_data", wr_data, 0);
        check("rst bus_d_oe", bus_d_oe, 0);
        check("rst strobes", {rd_req, rd_done, wr_strobe, timeout}, 0);

        snap();
        bus_cycle(1'b0, 3'd0, 8'hAA, 1'b0, 250);
        repeat (2) @(posedge clk);
        check("wr1 count", n_wr - s_wr, 1);
        check("wr1 addr", lw_addr, 0);
        check("wr1 data", lw_data, 8'hAA);
        check("wr1 no rd_req", n_rq - s_rq, 0);
        check("wr1 latency", wr_cyc - fall_cyc, 3);

        snap();
        bus_cycle(1'b1, 3'd3, 8'h00, 1'b0, 250);
        repeat (2) @(posedge clk);
        check("rd3 rd_req count", n_rq - s_rq, 1);
        check("rd3 rd_req latency", rq_cyc - rise_cyc, 3);
        check("rd3 pad data", dout_pre, 8'h5A);
        check("rd3 oe before fall", oe_pre, 1);
        check("rd3 oe after fall", oe_post, 0);
        check("rd3 rd_done count", n_dn - s_dn, 1);
        check("rd3 rd_done latency", dn_cyc - fall_cyc, 3);

        snap();
        bus_cycle(1'b0, 3'd0, 8'h55, 1'b1, 250);
        repeat (2) @(posedge clk);
        check("cs_n rd_req", n_rq - s_rq, 0);
        check("cs_n wr_strobe", n_wr - s_wr, 0);
        check("cs_n rd_done", n_dn - s_dn, 0);

        snap();
        @(posedge clk);
        #7;
        bus_a = 3'd5; bus_rw_n = 1'b0; bus_cs_n = 1'b0; bus_d_in = 8'h77;
        #30 bus_phy2 = 1'b1;
        #80 bus_res_n = 1'b0;
        #50;
        check("rstmid rd_addr", rd_addr, 0);
        check("rstmid wr_data", wr_data, 0);
        check("rstmid outputs", {bus_d_oe, rd_req, rd_done, wr_strobe, timeout}, 0);
        #50 bus_res_n = 1'b1;
        #120 bus_phy2 = 1'b0;
        #10 bus_cs_n = 1'b1;
        #300;
        check("rstmid no wr_strobe", n_wr - s_wr, 0);
        snap();
        bus_cycle(1'b0, 3'd5, 8'h33, 1'b0, 250);
        repeat (2) @(posedge clk);
        check("post-rst wr count", n_wr - s_wr, 1);
        check("post-rst wr addr", lw_addr, 5);
        check("post-rst wr data", lw_data, 8'h33);

        snap();
        bus_cycle(1'b1, 3'd2, 8'h00, 1'b0, 2000);
        repeat (2) @(posedge clk);
        check("to count", n_to - s_to, 1);
        check("to latency", to_cyc - rise_cyc, 34);
        check("to no rd_done", n_dn - s_dn, 0);

        snap();
        bus_cycle(1'b0, 3'd1, 8'h11, 1'b0, 250);
        check("b2b wr1 addr", lw_addr, 1);
        check("b2b wr1 data", lw_data, 8'h11);
        bus_cycle(1'b1, 3'd1, 8'h00, 1'b0, 250);
        check("b2b rd data", dout_pre, 8'h11);
        bus_cycle(1'b0, 3'd2, 8'h22, 1'b0, 250);
        repeat (2) @(posedge clk);
        check("b2b wr count", n_wr - s_wr, 2);
        check("b2b rd_done count", n_dn - s_dn, 1);
        check("b2b wr2 addr", lw_addr, 2);
        check("b2b wr2 data", lw_data, 8'h22);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
